// File: rtl/msix_bridge_pkg.sv
// rtl/msix_bridge_pkg.sv - shared state type, response codes and byte-merge helper for the MSI-X AXI-Lite bridge
package msix_bridge_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_ISSUE,
        RMW_RD,
        RMW_WAIT,
        RMW_WR,
        B_RESP,
        RD_ISSUE,
        RD_WAIT,
        R_RESP
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Select the new byte where the write strobe is set, otherwise keep the stored byte
    function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       take_new);
        return take_new ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/msix_axil_rd_pipe.sv
// rtl/msix_axil_rd_pipe.sv - memory read latency tracker and read-word capture shared by read and RMW paths
module msix_axil_rd_pipe
    import msix_bridge_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH       = 32,
    parameter int unsigned C_MEM_READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [C_DATA_WIDTH-1:0] mem_rdata_i,
    output logic                    hit_o,
    output logic [C_DATA_WIDTH-1:0] data_o
);

    logic [C_MEM_READ_LATENCY-1:0] vld_q;
    logic [C_MEM_READ_LATENCY:0]   shift_w;
    logic [C_DATA_WIDTH-1:0]       data_q;

    // The top bit of the shifted vector marks the cycle in which memory rdata is valid
    assign shift_w = {vld_q, start_i};
    assign hit_o   = shift_w[C_MEM_READ_LATENCY];
    assign data_o  = data_q;

    // Advance the issued-read marker one stage per cycle and capture the word when it lands
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q <= shift_w[C_MEM_READ_LATENCY-1:0];
            if (hit_o) begin
                data_q <= mem_rdata_i;
            end
        end
    end

endmodule

// File: rtl/msix_axil_mem_bridge.sv
// rtl/msix_axil_mem_bridge.sv - AXI4-Lite slave to msix_manager_br mem port bridge; MSIX_AXIL_BRIDGE_RMW_EN enables partial-write RMW
module msix_axil_mem_bridge
    import msix_bridge_pkg::*;
#(
    parameter int unsigned             C_ADDR_WIDTH       = 9,
    parameter int unsigned             C_DATA_WIDTH       = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_ADDR_LIMIT       = 9'h104,
    parameter int unsigned             C_MEM_READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [C_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [C_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic [C_ADDR_WIDTH-1:0]   m_mem_iface_waddr,
    output logic [C_ADDR_WIDTH-1:0]   m_mem_iface_raddr,
    output logic [C_DATA_WIDTH-1:0]   m_mem_iface_wdata,
    input  logic [C_DATA_WIDTH-1:0]   m_mem_iface_rdata,
    output logic                      m_mem_iface_we_norread
);

    bridge_state_e           state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    last_wr_q, last_wr_d;

    logic                    wr_elig, rd_elig;
    logic                    take_wr, take_rd;
    logic                    pipe_start, pipe_hit;
    logic [C_DATA_WIDTH-1:0] pipe_data;

`ifdef MSIX_AXIL_BRIDGE_RMW_EN
    logic [C_DATA_WIDTH/8-1:0] strb_q, strb_d;
    logic [C_DATA_WIDTH-1:0]   merged_w;
`endif

    // Arbitration: accepts happen only in IDLE; on contention the side not served last wins
    assign wr_elig = s_axil_awvalid && s_axil_wvalid;
    assign rd_elig = s_axil_arvalid;
    assign take_wr = !rst && (state_q == IDLE) && wr_elig && (!rd_elig || !last_wr_q);
    assign take_rd = !rst && (state_q == IDLE) && rd_elig && (!wr_elig || last_wr_q);

    assign s_axil_awready = take_wr;
    assign s_axil_wready  = take_wr;
    assign s_axil_arready = take_rd;
    assign s_axil_bvalid  = (state_q == B_RESP);
    assign s_axil_rvalid  = (state_q == R_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rresp   = rresp_q;
    // Error reads return zero regardless of whatever the capture register last held
    assign s_axil_rdata   = (rresp_q == RESP_OKAY) ? pipe_data : '0;

    assign m_mem_iface_waddr      = addr_q;
    assign m_mem_iface_raddr      = addr_q;
    assign m_mem_iface_wdata      = wdata_q;
    assign m_mem_iface_we_norread = !rst && ((state_q == WR_ISSUE) || (state_q == RMW_WR));

    msix_axil_rd_pipe #(
        .C_DATA_WIDTH       (C_DATA_WIDTH),
        .C_MEM_READ_LATENCY (C_MEM_READ_LATENCY)
    ) u_rd_pipe (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (pipe_start),
        .mem_rdata_i (m_mem_iface_rdata),
        .hit_o       (pipe_hit),
        .data_o      (pipe_data)
    );

`ifdef MSIX_AXIL_BRIDGE_RMW_EN
    // Overlay the strobed bytes of the pending write on the word just read back
    always_comb begin
        merged_w = '0;
        for (int b = 0; b < C_DATA_WIDTH / 8; b++) begin
            merged_w[b*8 +: 8] = merge_byte(m_mem_iface_rdata[b*8 +: 8], wdata_q[b*8 +: 8], strb_q[b]);
        end
    end
`endif

    // Next-state and datapath-register decode for the single-transaction FSM
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bresp_d    = bresp_q;
        rresp_d    = rresp_q;
        last_wr_d  = last_wr_q;
        pipe_start = 1'b0;
`ifdef MSIX_AXIL_BRIDGE_RMW_EN
        strb_d     = strb_q;
`endif
        case (state_q)
            IDLE: begin
                if (take_wr) begin
                    addr_d    = {s_axil_awaddr[C_ADDR_WIDTH-1:2], 2'b00};
                    wdata_d   = s_axil_wdata;
                    last_wr_d = 1'b1;
                    if (s_axil_awaddr >= C_ADDR_LIMIT) begin
                        bresp_d = RESP_SLVERR;
                        state_d = B_RESP;
                    end else if (&s_axil_wstrb) begin
                        bresp_d = RESP_OKAY;
                        state_d = WR_ISSUE;
                    end else if (s_axil_wstrb == '0) begin
                        bresp_d = RESP_OKAY;
                        state_d = B_RESP;
                    end else begin
`ifdef MSIX_AXIL_BRIDGE_RMW_EN
                        strb_d  = s_axil_wstrb;
                        bresp_d = RESP_OKAY;
                        state_d = RMW_RD;
`else
                        bresp_d = RESP_SLVERR;
                        state_d = B_RESP;
`endif
                    end
                end else if (take_rd) begin
                    addr_d    = {s_axil_araddr[C_ADDR_WIDTH-1:2], 2'b00};
                    last_wr_d = 1'b0;
                    if (s_axil_araddr >= C_ADDR_LIMIT) begin
                        rresp_d = RESP_SLVERR;
                        state_d = R_RESP;
                    end else begin
                        rresp_d = RESP_OKAY;
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR_ISSUE: state_d = B_RESP;
            RD_ISSUE: begin
                pipe_start = 1'b1;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                if (pipe_hit) begin
                    state_d = R_RESP;
                end
            end
`ifdef MSIX_AXIL_BRIDGE_RMW_EN
            RMW_RD: begin
                pipe_start = 1'b1;
                state_d    = RMW_WAIT;
            end
            RMW_WAIT: begin
                if (pipe_hit) begin
                    wdata_d = merged_w;
                    state_d = RMW_WR;
                end
            end
            RMW_WR: state_d = B_RESP;
`endif
            B_RESP: begin
                if (s_axil_bready) begin
                    state_d = IDLE;
                end
            end
            R_RESP: begin
                if (s_axil_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight without a response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            last_wr_q <= 1'b0;
`ifdef MSIX_AXIL_BRIDGE_RMW_EN
            strb_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            last_wr_q <= last_wr_d;
`ifdef MSIX_AXIL_BRIDGE_RMW_EN
            strb_q    <= strb_d;
`endif
        end
    end

endmodule

// File: tb/tb_msix_axil_mem_bridge.sv
// tb/tb_msix_axil_mem_bridge.sv - directed self-checking bench for msix_axil_mem_bridge
`timescale 1ns/1ps
module tb_msix_axil_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  s_axil_awaddr;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid, s_axil_bready;
    logic [8:0]  s_axil_araddr;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid, s_axil_rready;
    logic [8:0]  m_waddr, m_raddr;
    logic [31:0] m_wdata, m_rdata;
    logic        m_we;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    msix_axil_mem_bridge dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_axil_awaddr          (s_axil_awaddr),
        .s_axil_awvalid         (s_axil_awvalid),
        .s_axil_awready         (s_axil_awready),
        .s_axil_wdata           (s_axil_wdata),
        .s_axil_wstrb           (s_axil_wstrb),
        .s_axil_wvalid          (s_axil_wvalid),
        .s_axil_wready          (s_axil_wready),
        .s_axil_bresp           (s_axil_bresp),
        .s_axil_bvalid          (s_axil_bvalid),
        .s_axil_bready          (s_axil_bready),
        .s_axil_araddr          (s_axil_araddr),
        .s_axil_arvalid         (s_axil_arvalid),
        .s_axil_arready         (s_axil_arready),
        .s_axil_rdata           (s_axil_rdata),
        .s_axil_rresp           (s_axil_rresp),
        .s_axil_rvalid          (s_axil_rvalid),
        .s_axil_rready          (s_axil_rready),
        .m_mem_iface_waddr      (m_waddr),
        .m_mem_iface_raddr      (m_raddr),
        .m_mem_iface_wdata      (m_wdata),
        .m_mem_iface_rdata      (m_rdata),
        .m_mem_iface_we_norread (m_we)
    );

    // Memory model with one cycle read latency
    logic [31:0] mem [0:127];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
        end else if (m_we) begin
            mem[m_waddr[8:2]] <= m_wdata;
        end
        m_rdata <= mem[m_raddr[8:2]];
    end

    // Write-pulse monitor
    int         we_cnt = 0;
    int         oor_we = 0;
    int         rst_we = 0;
    logic [8:0] last_waddr = 9'h0;
    always @(negedge clk) begin
        if (m_we === 1'b1) begin
            we_cnt++;
            last_waddr = m_waddr;
            if (m_waddr >= 9'h104) oor_we++;
            if (rst === 1'b1) rst_we++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s, input int hold,
                             output logic [1:0] resp, output int lat, output int bad);
        int n;
        resp = 2'b11;
        bad  = 0;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        #1;
        n = 0;
        while (s_axil_awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1) bad++;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        lat = 1;
        while (s_axil_bvalid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        resp = s_axil_bresp;
        if (hold > 0) begin
            s_axil_araddr = 9'h0; s_axil_arvalid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== resp || s_axil_arready !== 1'b0) bad++;
            end
            s_axil_arvalid = 1'b0;
        end
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0;
        if (s_axil_bvalid !== 1'b0) bad++;
    endtask

    task automatic axi_read(input logic [8:0] a, input int hold,
                            output logic [31:0] data, output logic [1:0] resp, output int lat, output int bad);
        int n;
        bad = 0;
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        #1;
        n = 0;
        while (s_axil_arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (s_axil_arready !== 1'b1) bad++;
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        lat = 1;
        while (s_axil_rvalid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        data = s_axil_rdata;
        resp = s_axil_rresp;
        if (hold > 0) begin
            s_axil_awaddr = 9'h0; s_axil_wdata = 32'h0; s_axil_wstrb = 4'h0;
            s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== data || s_axil_rresp !== resp ||
                    s_axil_awready !== 1'b0) bad++;
            end
            s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        end
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
        if (s_axil_rvalid !== 1'b0) bad++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [3:0]  order;
        int          lat, bad, we0, acc, n;

        rst = 1'b1; mem_clr = 1'b1;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
        s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_handshake", 32'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid}), 32'h0);
        check("rst_resp", 32'({s_axil_bresp, s_axil_rresp}), 32'h0);
        check("rst_rdata", s_axil_rdata, 32'h0);
        check("rst_mem_addr", 32'({m_waddr, m_raddr}), 32'h0);
        check("rst_mem_wdata_we", 32'({m_wdata, m_we}), 32'h0);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);

        // Full write then read back
        we0 = we_cnt;
        axi_write(9'h000, 32'h0000_FFF0, 4'hF, 0, resp, lat, bad);
        check("fw_bresp", 32'(resp), 32'h0);
        check("fw_latency", 32'(lat), 32'd2);
        check("fw_we_pulses", 32'(we_cnt - we0), 32'd1);
        check("fw_waddr", 32'(last_waddr), 32'h0);
        check("fw_handshake", 32'(bad), 32'd0);
        axi_read(9'h000, 0, data, resp, lat, bad);
        check("rd_data", data, 32'h0000_FFF0);
        check("rd_rresp", 32'(resp), 32'h0);
        check("rd_latency", 32'(lat), 32'd3);

        // Unaligned byte address goes to the aligned word
        axi_read(9'h002, 0, data, resp, lat, bad);
        check("rd_unaligned", data, 32'h0000_FFF0);

        // Partial writes
        axi_write(9'h008, 32'hCAFE_0000, 4'hF, 0, resp, lat, bad);
        we0 = we_cnt;
        axi_write(9'h008, 32'h0000_AB00, 4'b0010, 0, resp, lat, bad);
`ifdef MSIX_AXIL_BRIDGE_RMW_EN
        check("pw_bresp", 32'(resp), 32'h0);
        check("pw_we_pulses", 32'(we_cnt - we0), 32'd1);
`else
        check("pw_bresp", 32'(resp), 32'h2);
        check("pw_we_pulses", 32'(we_cnt - we0), 32'd0);
`endif
        we0 = we_cnt;
        axi_write(9'h008, 32'hFFFF_FFFF, 4'b0000, 0, resp, lat, bad);
        check("zs_bresp", 32'(resp), 32'h0);
        check("zs_we_pulses", 32'(we_cnt - we0), 32'd0);
        axi_read(9'h008, 0, data, resp, lat, bad);
`ifdef MSIX_AXIL_BRIDGE_RMW_EN
        check("pw_readback", data, 32'hCAFE_AB00);
`else
        check("pw_readback", data, 32'hCAFE_0000);
`endif

        // Contention: last served was a read, so write goes first, then alternate
        s_axil_awaddr = 9'h010; s_axil_wdata = 32'h1111_2222; s_axil_wstrb = 4'hF; s_axil_araddr = 9'h010;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;
        #1;
        order = 4'h0; acc = 0; n = 0;
        while (acc < 4 && n < 200) begin
            if (s_axil_awready === 1'b1) begin order = {order[2:0], 1'b1}; acc++; end
            else if (s_axil_arready === 1'b1) begin order = {order[2:0], 1'b0}; acc++; end
            @(negedge clk);
            n++;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        repeat (6) @(negedge clk);
        s_axil_bready = 1'b0; s_axil_rready = 1'b0;
        check("rr_accepts", 32'(acc), 32'd4);
        check("rr_order", 32'(order), 32'b1010);

        // Address limit: last in-range word, then out of range
        axi_write(9'h100, 32'h0000_5A5A, 4'hF, 0, resp, lat, bad);
        axi_read(9'h100, 0, data, resp, lat, bad);
        check("pba_data", data, 32'h0000_5A5A);
        check("pba_rresp", 32'(resp), 32'h0);
        axi_read(9'h104, 0, data, resp, lat, bad);
        check("oor_rresp", 32'(resp), 32'h2);
        check("oor_rdata", data, 32'h0);
        we0 = we_cnt;
        axi_write(9'h1FC, 32'hDEAD_BEEF, 4'hF, 0, resp, lat, bad);
        check("oor_bresp", 32'(resp), 32'h2);
        check("oor_we_pulses", 32'(we_cnt - we0), 32'd0);

        // Back-pressure on responses
        axi_write(9'h020, 32'h1234_5678, 4'hF, 10, resp, lat, bad);
        check("bstall_resp", 32'(resp), 32'h0);
        check("bstall_stable", 32'(bad), 32'd0);
        axi_read(9'h020, 10, data, resp, lat, bad);
        check("rstall_data", data, 32'h1234_5678);
        check("rstall_stable", 32'(bad), 32'd0);

        // Reset during RD_WAIT
        s_axil_araddr = 9'h000; s_axil_arvalid = 1'b1;
        #1;
        n = 0;
        while (s_axil_arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_handshake", 32'({s_axil_awready, s_axil_arready, s_axil_bvalid, s_axil_rvalid, m_we}), 32'h0);
        check("mid_rst_rdata", s_axil_rdata, 32'h0);
        check("mid_rst_mem", 32'({m_waddr, m_raddr}), 32'h0);
        check("mid_rst_wdata", m_wdata, 32'h0);
        rst = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_axil_rvalid !== 1'b0) bad++;
        end
        check("mid_rst_no_rvalid", 32'(bad), 32'd0);
        axi_read(9'h000, 0, data, resp, lat, bad);
        check("post_rst_data", data, 32'h0000_FFF0);
        check("post_rst_latency", 32'(lat), 32'd3);

        check("oor_we_seen", 32'(oor_we), 32'd0);
        check("rst_we_seen", 32'(rst_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
